// File: rtl/cpu_fetch_pkg.sv
// Shared types and reset defaults for the instruction-fetch stage.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        KILL,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit and the memory side.
interface if_fetch_unit_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );

endinterface

// File: rtl/if_id_buffer.sv
// One-entry skid buffer plus the IF/ID pipeline register; pure datapath steered by
// strobes from the fetch FSM.
module if_id_buffer
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_mem_i,
    input  logic        load_buf_i,
    input  logic        bubble_i,
    input  logic        buf_wr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] buf_q;
    logic        buf_vld_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q     <= NOP_INSTR;
            buf_vld_q <= 1'b0;
            pc_q      <= '0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
        end else begin
            if (buf_wr_i) begin
                buf_q     <= rdata_i;
                buf_vld_q <= 1'b1;
            end else if (load_buf_i || bubble_i) begin
                buf_vld_q <= 1'b0;
            end

            // Bubbles keep the last PC; only instr/valid are meaningful.
            if (bubble_i) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else if (load_mem_i) begin
                pc_q    <= pc_i;
                instr_q <= rdata_i;
                valid_q <= 1'b1;
            end else if (load_buf_i) begin
                pc_q    <= pc_i;
                instr_q <= buf_q;
                valid_q <= buf_vld_q;
            end
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: sequences memory requests, handles stalls and jump
// redirection, and feeds the IF/ID register.
module if_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pc_stall,
    input  logic                   instruction_stall,
    input  logic                   pc_jump_confirm,
    input  logic [31:0]            pc_jump_addr,
    if_fetch_unit_if.master        im,
    output logic [31:0]            if_id_pc,
    output logic [31:0]            if_id_instr,
    output logic                   if_id_valid,
    output logic                   fetch_busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic         im_req_q;
    logic [31:0]  jump_tgt;
    logic         advance;
    logic         load_mem, load_buf, bubble, buf_wr;

    assign advance  = !pc_stall && !instruction_stall;
    assign jump_tgt = pc_jump_addr & PC_ALIGN_MASK;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        load_mem = 1'b0;
        load_buf = 1'b0;
        bubble   = 1'b0;
        buf_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (pc_jump_confirm) begin
                    pc_d   = jump_tgt;
                    bubble = 1'b1;
                end
            end
            FETCH: begin
                if (im.im_ack) begin
                    if (pc_jump_confirm) begin
                        pc_d   = jump_tgt;
                        bubble = 1'b1;
                    end else if (advance) begin
                        load_mem = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end else begin
                        buf_wr  = 1'b1;
                        state_d = HOLD;
                    end
                end else if (pc_jump_confirm) begin
                    // Request still in flight: park the target until it returns.
                    tgt_d   = jump_tgt;
                    bubble  = 1'b1;
                    state_d = KILL;
                end else if (!instruction_stall) begin
                    bubble = 1'b1;
                end
            end
            KILL: begin
                bubble = 1'b1;
                if (pc_jump_confirm) begin
                    tgt_d = jump_tgt;
                end
                if (im.im_ack) begin
                    pc_d    = tgt_d;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (pc_jump_confirm) begin
                    pc_d    = jump_tgt;
                    bubble  = 1'b1;
                    state_d = FETCH;
                end else if (advance) begin
                    load_buf = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            tgt_q    <= RESET_PC;
            im_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            im_req_q <= (state_d == FETCH) || (state_d == KILL);
        end
    end

    assign im.im_req  = im_req_q;
    assign im.im_addr = pc_q;

    assign fetch_busy = (state_q == IDLE) || (state_q == KILL) ||
                        ((state_q == FETCH) && !im.im_ack);

    if_id_buffer #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_buffer (
        .clk       (clk),
        .rst       (rst),
        .load_mem_i(load_mem),
        .load_buf_i(load_buf),
        .bubble_i  (bubble),
        .buf_wr_i  (buf_wr),
        .pc_i      (pc_q),
        .rdata_i   (im.im_rdata),
        .pc_o      (if_id_pc),
        .instr_o   (if_id_instr),
        .valid_o   (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed scenarios followed by randomized traffic, checked against a
// transaction-level model of the fetch stage.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_stall, instruction_stall, pc_jump_confirm;
    logic [31:0] pc_jump_addr;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid, fetch_busy;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    if_fetch_unit_if im_if();

    if_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_stall         (pc_stall),
        .instruction_stall(instruction_stall),
        .pc_jump_confirm  (pc_jump_confirm),
        .pc_jump_addr     (pc_jump_addr),
        .im               (im_if),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr),
        .if_id_valid      (if_id_valid),
        .fetch_busy       (fetch_busy)
    );

    always #5 clk = ~clk;

    // Model: waiting-one-cycle flag, fetch address, pending redirect, held words.
    bit          m_idle, m_kill;
    logic [31:0] m_pc, m_tgt;
    logic [31:0] held[$];
    logic [31:0] e_pc, e_instr;
    bit          e_valid;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit model_req();
        return !m_idle && (held.size() == 0);
    endfunction

    task automatic model_reset();
        m_idle = 1; m_kill = 0; m_pc = RST_PC; m_tgt = RST_PC;
        held.delete();
        e_pc = '0; e_instr = NOP; e_valid = 0;
    endtask

    task automatic flush();
        e_instr = NOP; e_valid = 0;
    endtask

    task automatic deliver(input logic [31:0] instr);
        e_pc = m_pc; e_instr = instr; e_valid = 1;
        m_pc = m_pc + 32'd4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, im_if.im_req}, 32'd0);
        chk({tag, "_addr"},  im_if.im_addr, RST_PC);
        chk({tag, "_pc"},    if_id_pc, 32'd0);
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, fetch_busy}, 32'd1);
    endtask

    task automatic check_outputs(input bit ack);
        bit exp_busy;
        exp_busy = m_idle || m_kill || ((held.size() == 0) && !ack);
        chk("im_req", {31'd0, im_if.im_req}, {31'd0, model_req()});
        if (model_req() || m_idle) chk("im_addr", im_if.im_addr, m_pc);
        chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, exp_busy});
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e_valid});
        chk("if_id_instr", if_id_instr, e_instr);
        if (e_valid) chk("if_id_pc", if_id_pc, e_pc);
    endtask

    // One clock: drive at negedge, check, advance model, wait for next negedge.
    task automatic step(input bit r, input bit ps, input bit is, input bit j,
                        input logic [31:0] ja, input bit ack);
        logic [31:0] tgt;
        bit adv;
        rst = r; pc_stall = ps; instruction_stall = is;
        pc_jump_confirm = j; pc_jump_addr = ja;
        im_if.im_ack   = ack;
        im_if.im_rdata = ack ? mem_of(m_pc) : 32'hDEAD_BEEF;
        #1;
        check_outputs(ack);
        tgt = {ja[31:2], 2'b00};
        adv = !ps && !is;
        if (r) begin
            model_reset();
        end else if (m_idle) begin
            m_idle = 0;
            if (j) begin m_pc = tgt; flush(); end
        end else if (held.size() != 0) begin
            if (j) begin held.delete(); m_pc = tgt; flush(); end
            else if (adv) deliver(held.pop_front());
        end else if (m_kill) begin
            flush();
            if (j) m_tgt = tgt;
            if (ack) begin m_pc = m_tgt; m_kill = 0; end
        end else if (ack) begin
            if (j) begin m_pc = tgt; flush(); end
            else if (adv) deliver(mem_of(m_pc));
            else held.push_back(mem_of(m_pc));
        end else if (j) begin
            m_tgt = tgt; m_kill = 1; flush();
        end else if (!is) begin
            flush();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; pc_stall = 0; instruction_stall = 0;
        pc_jump_confirm = 0; pc_jump_addr = '0;
        im_if.im_ack = 0; im_if.im_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("rst_hold");
        step(1, 0, 0, 0, 32'h0, 0);

        // Release with single-cycle acks.
        step(0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s1_addr4", im_if.im_addr, 32'h4);
        chk("s1_pc0", if_id_pc, 32'h0);
        chk("s1_valid", {31'd0, if_id_valid}, 32'd1);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s1_addr8", im_if.im_addr, 32'h8);
        chk("s1_pc4", if_id_pc, 32'h4);

        // Ack at 8 under full stall for two cycles.
        step(0, 1, 1, 0, 32'h0, 1);
        chk("s2_req_off", {31'd0, im_if.im_req}, 32'd0);
        chk("s2_pc_hold", if_id_pc, 32'h4);
        step(0, 1, 1, 0, 32'h0, 0);
        chk("s2_req_off2", {31'd0, im_if.im_req}, 32'd0);
        chk("s2_pc_hold2", if_id_pc, 32'h4);
        step(0, 0, 0, 0, 32'h0, 0);
        chk("s2_rel_pc", if_id_pc, 32'h8);
        chk("s2_rel_addr", im_if.im_addr, 32'hC);

        // Jump with same-cycle ack.
        step(0, 0, 0, 1, 32'h0000_0103, 1);
        chk("s3_addr", im_if.im_addr, 32'h0000_0100);
        chk("s3_bubble", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s3_pc", if_id_pc, 32'h0000_0100);

        // Jump while the ack is delayed three cycles.
        step(0, 0, 0, 1, 32'h0000_0200, 0);
        chk("s4_addr_hold", im_if.im_addr, 32'h0000_0104);
        step(0, 0, 0, 0, 32'h0, 0);
        chk("s4_addr_hold2", im_if.im_addr, 32'h0000_0104);
        step(0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s4_addr_tgt", im_if.im_addr, 32'h0000_0200);
        chk("s4_discard", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0, 32'h0, 1);

        // PC wrap-around at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        chk("s5_addr_top", im_if.im_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s5_wrap", im_if.im_addr, 32'h0000_0000);
        chk("s5_pc_top", if_id_pc, 32'hFFFF_FFFC);

        // Reset during an outstanding request; ack in the IDLE cycle is ignored.
        step(0, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 32'h0, 0);
        chk_reset("s6_rst");
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s6_first_addr", im_if.im_addr, RST_PC);
        chk("s6_no_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0, 32'h0, 1);
        chk("s6_first_pc", if_id_pc, RST_PC);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, ps, is, j, ack;
            logic [31:0] ja;
            r   = ($urandom_range(63) == 0);
            ps  = ($urandom_range(3) == 0);
            is  = ($urandom_range(3) == 0);
            j   = ($urandom_range(7) == 0);
            ja  = $urandom();
            ack = model_req() && ($urandom_range(1) == 1);
            step(r, ps, is, j, ja, ack);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameters SHALL be: RESET_PC (default 32'h0000_0000, first fetch address) and NOP_INSTR (default 32'h0000_0013, bubble encoding).
REQ-003 The ports SHALL be (name, direction, width, meaning):
 clk  in  1  rising-edge clock
 rst  in  1  synchronous active-high reset
 pc_stall  in  1  hold PC, from load-hazard unit
 instruction_stall  in  1  hold IF/ID, from load-hazard unit
 pc_jump_confirm  in  1  branch/jump resolved taken
 pc_jump_addr  in  32  jump target
 im_req  out  1  instruction-memory request
 im_addr  out  32  fetch address
 im_ack  in  1  im_rdata valid, completes request
 im_rdata  in  32  fetched instruction
 if_id_pc  out  32  IF/ID register PC
 if_id_instr  out  32  IF/ID register instruction
 if_id_valid  out  1  IF/ID holds real instruction
 fetch_busy  out  1  fetch not delivering this cycle

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, KILL, HOLD; rst forces IDLE.
REQ-005 advance SHALL equal !pc_stall && !instruction_stall; pc_jump_confirm SHALL take priority over any stall.
REQ-006 IDLE SHALL last exactly one cycle, go to FETCH, and keep im_req=0.
REQ-007 In FETCH and KILL, im_req SHALL be 1, and im_addr SHALL stay stable until the cycle im_ack=1; an outstanding request SHALL never be abandoned.
REQ-008 FETCH with im_ack=1, no jump, advance=1: IF/ID SHALL load {pc, im_rdata, valid=1}, pc SHALL become pc+4, and the state SHALL stay FETCH, giving 1 instruction per cycle on single-cycle acks.
REQ-009 FETCH with im_ack=1, no jump, advance=0: im_rdata SHALL go to the one-entry buffer, IF/ID SHALL hold, and the state SHALL go to HOLD.
REQ-010 FETCH with im_ack=0, no jump: IF/ID SHALL hold if instruction_stall=1; otherwise it SHALL load a bubble {valid=0, instr=NOP_INSTR}.
REQ-011 HOLD: im_req SHALL be 0. Once advance=1, IF/ID SHALL load the buffer, pc SHALL become pc+4, and the state SHALL go to FETCH.
REQ-012 pc_jump_confirm=1 with im_ack=1 (FETCH) or in HOLD or IDLE: data/buffer SHALL be discarded, pc SHALL become {pc_jump_addr[31:2],2'b00}, IF/ID SHALL be flushed to a bubble, and the next state SHALL be FETCH.
REQ-013 pc_jump_confirm=1 in FETCH with im_ack=0: the target SHALL be stored, IF/ID SHALL be flushed, and the state SHALL go to KILL.
REQ-014 KILL: the returning data SHALL be discarded. On im_ack, pc SHALL become the stored target and the state SHALL go to FETCH. IF/ID SHALL stay a bubble, and a second jump in KILL SHALL overwrite the stored target.
REQ-015 PC arithmetic SHALL be 32-bit modulo (32'hFFFF_FFFC+4 = 0); bits [1:0] SHALL always be 0.
REQ-016 fetch_busy SHALL be combinational: 1 in IDLE and KILL, 1 in FETCH with im_ack=0, and 0 otherwise.

Reset
REQ-017 While rst=1 the outputs SHALL be: im_req=0, im_addr=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, fetch_busy=1; pc=RESET_PC and the buffer SHALL be invalid.
REQ-018 rst asserted mid-request SHALL drop the request; an im_ack arriving in the IDLE cycle after reset SHALL be ignored.

Structure
REQ-019 The package cpu_fetch_pkg SHALL hold the fetch_state_e enum, the RESET_PC default, and NOP_INSTR.
REQ-020 The one-entry buffer plus the IF/ID output register SHALL be sub-module if_id_buffer, containing no FSM logic.

Verification
REQ-021 The bench SHALL cover these scenarios:
 Reset release with single-cycle acks -> im_addr 0,4,8 on consecutive cycles, and if_id_pc 0,4 with valid=1.
 Ack at addr 8 while pc_stall=instruction_stall=1 for 2 cycles -> HOLD with im_req=0 and IF/ID unchanged; on release if_id_pc=8 and next im_addr=12.
 Jump to 32'h0000_0103 with ack the same cycle -> IF/ID bubble, next im_addr=32'h0000_0100, and stale instruction never valid.
 Jump while im_ack is delayed 3 cycles -> im_addr stable until ack, data discarded, then im_addr=target and fetch_busy=1 throughout.
 pc=32'hFFFF_FFFC accepted -> next im_addr=32'h0000_0000.
 rst pulsed during an outstanding request -> all outputs at reset values next cycle, and the first fetch after release is at RESET_PC.
